// File: rtl/output_channel_rr_buffered.sv
// ---------------------------------------------------------------------------
// output_channel_rr_buffered
//
// Router output port with packet-granular round-robin arbitration among
// NUMBER_CHANNELS crossbar inputs. The granted channel's words are written
// into an internal first-word-fall-through FIFO, and the FIFO head is
// presented downstream on a valid/ack interface. Because of the FIFO, the
// downstream ack does not stall the crossbar combinationally.
//
// Flit format: bit DATA_WIDTH-1 = bop, bit DATA_WIDTH-2 = eop.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   x_req      : per-channel request for this output
//   x_rok      : per-channel word available
//   x_din      : channel i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   x_gnt      : one-hot grant, held for a whole packet
//   x_rd       : one-hot read strobe, a word is consumed from channel i
//   out_data   : FIFO head word (0 while the FIFO is empty)
//   out_val    : FIFO non-empty
//   out_ack    : downstream accepts out_data this cycle
//   idle       : arbiter holds no grant
//   fifo_count : current FIFO occupancy
//   pkt_count  : packets delivered downstream (optional feature)
//
// Optional feature macro: OUTPUT_CHANNEL_PKT_COUNT_EN
//   defined     : pkt_count counts pops of eop words (16-bit, wrapping)
//   not defined : pkt_count is tied to 0, port list unchanged
// ---------------------------------------------------------------------------
module output_channel_rr_buffered #(
    parameter int DATA_WIDTH      = 70,
    parameter int NUMBER_CHANNELS = 5,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUMBER_CHANNELS-1:0]            x_req,
    input  logic [NUMBER_CHANNELS-1:0]            x_rok,
    input  logic [NUMBER_CHANNELS*DATA_WIDTH-1:0] x_din,
    output logic [NUMBER_CHANNELS-1:0]            x_gnt,
    output logic [NUMBER_CHANNELS-1:0]            x_rd,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_val,
    input  logic                                  out_ack,
    output logic                                  idle,
    output logic [FIFO_ADDR_WIDTH:0]              fifo_count,
    output logic [15:0]                           pkt_count
);

    localparam int CH_W = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUMBER_CHANNELS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [CH_W-1:0]            ptr;
    logic [CH_W-1:0]            next_ptr;
    logic [CH_W-1:0]            gnt_idx;
    logic [CH_W-1:0]            next_gnt_idx;
    logic [NUMBER_CHANNELS-1:0] next_gnt;
    logic [CH_W-1:0]            pick_idx;
    logic                       pick_found;

    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       push_eop;
    logic [DATA_WIDTH-1:0]      push_data;

    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;

    // Round-robin search: first requesting channel at or after the pointer,
    // wrapping modulo NUMBER_CHANNELS.
    always_comb begin
        logic [CH_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 0; k < NUMBER_CHANNELS; k++) begin
            cand_idx = CH_W'((int'(ptr) + k) % NUMBER_CHANNELS);
            if (!pick_found && x_req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Write path. A write on a full FIFO is refused even when a pop happens
    // in the same cycle, so the read strobe depends only on the registered
    // occupancy and never on out_ack.
    assign full      = (fifo_count == FULL_COUNT);
    assign x_rd      = (state == BUSY) ? (x_gnt & x_rok & {NUMBER_CHANNELS{~full}})
                                       : '0;
    assign push      = |x_rd;
    assign push_data = x_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign push_eop  = push & push_data[DATA_WIDTH-2];
    assign pop       = out_val & out_ack;

    assign idle      = (state == IDLE);

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x_gnt   <= '0;
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= next_state;
            x_gnt   <= next_gnt;
            ptr     <= next_ptr;
            gnt_idx <= next_gnt_idx;
        end
    end

    // Arbiter next state. The grant is released only when the eop word has
    // actually been written; dropping x_req mid-packet is ignored.
    always_comb begin
        next_state   = state;
        next_gnt     = x_gnt;
        next_ptr     = ptr;
        next_gnt_idx = gnt_idx;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    next_state             = BUSY;
                    next_gnt               = '0;
                    next_gnt[pick_idx]     = 1'b1;
                    next_gnt_idx           = pick_idx;
                end
            end
            BUSY: begin
                if (push_eop) begin
                    next_state = IDLE;
                    next_gnt   = '0;
                    next_ptr   = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_gnt   = '0;
            end
        endcase
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two; occupancy is tracked separately so full and empty
    // are never ambiguous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is not reset; stale contents are hidden by the occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // First-word-fall-through head, forced to zero while empty.
    assign out_val  = (fifo_count != '0);
    assign out_data = out_val ? mem[rd_ptr] : '0;

`ifdef OUTPUT_CHANNEL_PKT_COUNT_EN
    logic [15:0] pkt_count_q;

    // Counts packets as their eop word leaves the FIFO downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (pop && out_data[DATA_WIDTH-2]) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_output_channel_rr_buffered.sv
// ---------------------------------------------------------------------------
// tb_output_channel_rr_buffered
//
// Self-checking bench for output_channel_rr_buffered. Each input channel is
// modelled as a queue of whole packets; the reference keeps the granted
// channel, the round-robin pointer and the FIFO contents as plain integers
// and a queue, and predicts every output once per cycle. Directed phases
// cover the arbitration order, back-pressure on a full FIFO, a stalled
// source, reset mid-packet and the packet counter; a randomized phase
// follows.
// ---------------------------------------------------------------------------
module tb_output_channel_rr_buffered;

    localparam int DW    = 70;
    localparam int NCH   = 5;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef logic [DW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    x_req = '0;
    logic [NCH-1:0]    x_rok = '0;
    logic [NCH*DW-1:0] x_din = '0;
    logic [NCH-1:0]    x_gnt;
    logic [NCH-1:0]    x_rd;
    logic [DW-1:0]     out_data;
    logic              out_val;
    logic              out_ack = 1'b0;
    logic              idle;
    logic [AW:0]       fifo_count;
    logic [15:0]       pkt_count;

    int checks   = 0;
    int failures = 0;

    // Source channels and reference model state.
    word_t          chan_q [NCH][$];
    word_t          m_fifo [$];
    int             m_gnt;
    int             m_ptr;
    logic [15:0]    m_pkts;
    logic [NCH-1:0] m_rd;
    int             gnt_log [$];

    // Stimulus knobs.
    int             ack_pct = 100;
    int             rok_pct = 100;
    int             req_pct = 100;
    logic [NCH-1:0] rok_block = '0;

    output_channel_rr_buffered #(
        .DATA_WIDTH      (DW),
        .NUMBER_CHANNELS (NCH),
        .FIFO_DEPTH      (DEPTH),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_req      (x_req),
        .x_rok      (x_rok),
        .x_din      (x_din),
        .x_gnt      (x_gnt),
        .x_rd       (x_rd),
        .out_data   (out_data),
        .out_val    (out_val),
        .out_ack    (out_ack),
        .idle       (idle),
        .fifo_count (fifo_count),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic word_t makeWord(input logic bop, input logic eop);
        word_t w;
        w[31:0]   = $urandom();
        w[63:32]  = $urandom();
        w[67:64]  = 4'($urandom_range(15));
        w[DW-1]   = bop;
        w[DW-2]   = eop;
        return w;
    endfunction

    task automatic addPacket(input int ch, input int len);
        for (int i = 0; i < len; i++) begin
            chan_q[ch].push_back(makeWord(i == 0, i == len - 1));
        end
    endtask

    function automatic logic pending();
        logic p;
        p = (m_gnt >= 0) || (m_fifo.size() > 0);
        for (int i = 0; i < NCH; i++) begin
            if (chan_q[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    // Drive all inputs for the coming cycle from the source queues.
    task automatic applyStimulus();
        for (int i = 0; i < NCH; i++) begin
            if (chan_q[i].size() > 0) begin
                x_din[i*DW +: DW] = chan_q[i][0];
                x_req[i] = (int'($urandom_range(99)) < req_pct);
                x_rok[i] = !rok_block[i] && (int'($urandom_range(99)) < rok_pct);
            end else begin
                x_din[i*DW +: DW] = makeWord(1'b0, 1'b0);
                x_req[i] = 1'b0;
                x_rok[i] = 1'b0;
            end
        end
        out_ack = (int'($urandom_range(99)) < ack_pct);
    endtask

    // Compare every output against the model's prediction for this cycle.
    task automatic compareModel();
        logic [NCH-1:0] e_gnt;
        word_t          e_data;
        logic [15:0]    e_pkt;
        e_gnt = '0;
        m_rd  = '0;
        if (m_gnt >= 0) begin
            e_gnt[m_gnt] = 1'b1;
            if (x_rok[m_gnt] && m_fifo.size() < DEPTH) m_rd[m_gnt] = 1'b1;
        end
        e_data = (m_fifo.size() > 0) ? m_fifo[0] : '0;
`ifdef OUTPUT_CHANNEL_PKT_COUNT_EN
        e_pkt = m_pkts;
`else
        e_pkt = '0;
`endif
        checkOutput("x_gnt", x_gnt, e_gnt);
        checkOutput("x_rd", x_rd, m_rd);
        checkOutput("idle", idle, m_gnt < 0);
        checkOutput("fifo_count", fifo_count, m_fifo.size());
        checkOutput("out_val", out_val, m_fifo.size() > 0);
        checkOutput("out_data", out_data, e_data);
        checkOutput("pkt_count", pkt_count, e_pkt);
    endtask

    // Advance the model across one rising edge.
    task automatic advanceModel();
        word_t w;
        if (m_fifo.size() > 0 && out_ack) begin
            if (m_fifo[0][DW-2]) m_pkts++;
            void'(m_fifo.pop_front());
        end
        if (m_gnt >= 0) begin
            if (m_rd != '0) begin
                w = chan_q[m_gnt].pop_front();
                m_fifo.push_back(w);
                if (w[DW-2]) begin
                    m_ptr = (m_gnt + 1) % NCH;
                    m_gnt = -1;
                end
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (x_req[c]) begin
                    m_gnt = c;
                    gnt_log.push_back(c);
                    break;
                end
            end
        end
    endtask

    task automatic runCycle();
        applyStimulus();
        #1;
        compareModel();
        advanceModel();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runUntilDrained(input string tag, input int bound);
        int n;
        n = 0;
        while (pending() && n < bound) begin
            runCycle();
            n++;
        end
        checkOutput({tag, "_drained"}, n < bound, 1'b1);
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic applyReset();
        rst     = 1'b1;
        x_req   = '0;
        x_rok   = '0;
        out_ack = 1'b0;
        #1;
        checkOutput("rst_out_val", out_val, 1'b0);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_x_gnt", x_gnt, 0);
        checkOutput("rst_x_rd", x_rd, 0);
        checkOutput("rst_idle", idle, 1'b1);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_pkt_count", pkt_count, 0);
        m_fifo.delete();
        m_gnt  = -1;
        m_ptr  = 0;
        m_pkts = '0;
        for (int i = 0; i < NCH; i++) chan_q[i].delete();
        gnt_log.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_order [6];
        int n;
        logic [15:0] exp_pkts;
        exp_order = '{0, 1, 4, 0, 1, 4};

        @(negedge clk);
        applyReset();

        // Single 3-word packet on channel 2 with ack held high.
        $display("[TB] phase 1: single packet on channel 2");
        addPacket(2, 3);
        runUntilDrained("p1", 50);
        checkOutput("p1_grant_ch", gnt_log.size() > 0 ? gnt_log[0] : -1, 2);

        // Three channels requesting continuously, two packets each.
        $display("[TB] phase 2: round-robin among channels 0, 1, 4");
        applyReset();
        for (int r = 0; r < 2; r++) begin
            addPacket(0, 2);
            addPacket(1, 2);
            addPacket(4, 2);
        end
        runUntilDrained("p2", 100);
        checkOutput("p2_grant_count", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
            checkOutput($sformatf("p2_order_%0d", i), gnt_log[i], exp_order[i]);
        end

        // Back-pressure: 20-word packet against a stalled downstream.
        $display("[TB] phase 3: full FIFO back-pressure");
        ack_pct = 0;
        addPacket(3, 20);
        for (int i = 0; i < 25; i++) runCycle();
        applyStimulus();
        #1;
        compareModel();
        checkOutput("p3_full_count", fifo_count, DEPTH);
        checkOutput("p3_full_x_rd", x_rd, 0);
        checkOutput("p3_full_x_gnt", x_gnt, 5'b01000);
        advanceModel();
        @(posedge clk);
        @(negedge clk);
        ack_pct = 100;
        runUntilDrained("p3", 100);

        // Granted source stalls mid-packet while another channel waits.
        $display("[TB] phase 4: stalled source keeps its grant");
        gnt_log.delete();
        addPacket(1, 8);
        for (int i = 0; i < 3; i++) runCycle();
        addPacket(0, 2);
        rok_block[1] = 1'b1;
        for (int i = 0; i < 5; i++) runCycle();
        checkOutput("p4_hold_gnt", x_gnt, 5'b00010);
        rok_block = '0;
        runUntilDrained("p4", 100);
        checkOutput("p4_grant_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            checkOutput("p4_first", gnt_log[0], 1);
            checkOutput("p4_second", gnt_log[1], 0);
        end

        // Reset while the FIFO holds 7 words and a grant is active.
        $display("[TB] phase 5: reset mid-packet");
        ack_pct = 0;
        addPacket(2, 10);
        n = 0;
        while (m_fifo.size() != 7 && n < 40) begin
            runCycle();
            n++;
        end
        checkOutput("p5_reach_7", fifo_count, 7);
        checkOutput("p5_gnt_active", x_gnt, 5'b00100);
        applyReset();
        ack_pct = 100;
        addPacket(3, 2);
        addPacket(0, 2);
        runUntilDrained("p5", 100);
        checkOutput("p5_first_after_rst", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // Three packets delivered, including a single-word packet.
        $display("[TB] phase 6: packet counter");
        applyReset();
        addPacket(4, 1);
        addPacket(0, 2);
        addPacket(2, 3);
        runUntilDrained("p6", 100);
`ifdef OUTPUT_CHANNEL_PKT_COUNT_EN
        exp_pkts = 16'd3;
`else
        exp_pkts = 16'd0;
`endif
        checkOutput("p6_pkt_count", pkt_count, exp_pkts);

        // Randomized traffic with varying ack, rok and req rates.
        $display("[TB] phase 7: randomized traffic");
        for (int seg = 0; seg < 8; seg++) begin
            ack_pct = int'($urandom_range(100, 20));
            rok_pct = int'($urandom_range(100, 30));
            req_pct = int'($urandom_range(100, 50));
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(99) < 15) begin
                    int ch;
                    ch = int'($urandom_range(NCH - 1));
                    if (chan_q[ch].size() < 20) addPacket(ch, int'($urandom_range(6, 1)));
                end
                runCycle();
            end
        end
        ack_pct = 100;
        rok_pct = 100;
        req_pct = 100;
        runUntilDrained("p7", 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
